cache_top: RTL and testbench

- 4-way set-associative, write-allocate data cache with FIFO replacement and no backing memory.
- Holds one 32-bit word per line, addressed by a 32-bit byte address.
- Serves one read or one write per cycle and reports a registered hit flag and read data one clock after the request.
- Sits as a standalone storage/lookup block between a requester and later memory-side logic; no refill or eviction interface in this revision.

---
 rtl/cache_top.sv | 88 ++++++++
 tb/tb_cache_top.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cache_top.sv
// rtl/cache_top.sv - 4-way set-associative write-allocate word cache with per-set FIFO replacement
module cache_top #(
    parameter int ADDR_W      = 32,
    parameter int OFFSET_BITS = 6,
    parameter int INDEX_BITS  = 4,
    parameter int WAYS        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [ADDR_W-1:0] write_data,
    output logic [ADDR_W-1:0] read_data,
    output logic              hit
);

    localparam int SETS  = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [WAYS-1:0]   valid    [SETS];
    logic [WAY_W-1:0]  fifo_ptr [SETS];
    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [ADDR_W-1:0] data_mem [SETS][WAYS];

    logic [INDEX_BITS-1:0] index;
    logic [TAG_W-1:0]      tag;
    logic                  lookup_hit;
    logic [WAY_W-1:0]      hit_way;
    logic [ADDR_W-1:0]     hit_data;
    logic [WAY_W-1:0]      wr_way;
    logic                  unused_offset;

    assign index         = address[OFFSET_BITS +: INDEX_BITS];
    assign tag           = address[ADDR_W-1 -: TAG_W];
    assign unused_offset = ^address[OFFSET_BITS-1:0];

    // Tags within a set are unique, so at most one way can match.
    always_comb begin
        lookup_hit = 1'b0;
        hit_way    = '0;
        hit_data   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[index][w] && (tag_mem[index][w] == tag)) begin
                lookup_hit = 1'b1;
                hit_way    = WAY_W'(w);
                hit_data   = data_mem[index][w];
            end
        end
    end

    assign wr_way = lookup_hit ? hit_way : fifo_ptr[index];

    // Tag/data storage is not reset; valid bits alone decide residency.
    always_ff @(posedge clk) begin
        if (reset && write) begin
            data_mem[index][wr_way] <= write_data;
            if (!lookup_hit) begin
                tag_mem[index][wr_way] <= tag;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s]    <= '0;
                fifo_ptr[s] <= '0;
            end
            hit       <= 1'b0;
            read_data <= '0;
        end else if (write) begin
            hit       <= lookup_hit;
            read_data <= write_data;
            if (!lookup_hit) begin
                valid[index][fifo_ptr[index]] <= 1'b1;
                fifo_ptr[index]               <= fifo_ptr[index] + WAY_W'(1);
            end
        end else if (read) begin
            hit       <= lookup_hit;
            read_data <= lookup_hit ? hit_data : '0;
        end else begin
            hit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_top.sv
// tb/tb_cache_top.sv - scoreboard bench for cache_top against a per-set FIFO list model
module tb_cache_top;

    logic        clk;
    logic        reset;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        hit;

    cache_top dut (
        .clk        (clk),
        .reset      (reset),
        .read       (read),
        .write      (write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .hit        (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        h;
        logic [31:0] d;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    compared   = 0;
    int    mismatched = 0;

    // Model: each set is an insertion-ordered list of resident lines, oldest first.
    logic [21:0] mtag [16][$];
    logic [31:0] mdat [16][$];
    logic [31:0] last_rd;

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            mtag[s].delete();
            mdat[s].delete();
        end
        last_rd = 32'h0;
    endtask

    task automatic check(input string nm, input logic h_act, input logic [31:0] d_act,
                         input logic h_exp, input logic [31:0] d_exp);
        compared++;
        if (h_act !== h_exp || d_act !== d_exp) begin
            mismatched++;
            $display("FAIL %s: got hit=%0b data=%h, expected hit=%0b data=%h",
                     nm, h_act, d_act, h_exp, d_exp);
        end
    endtask

    task automatic do_op(input string nm, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        int          s;
        logic [21:0] t;
        int          idx;
        exp_t        e;
        @(negedge clk);
        read       = r;
        write      = w;
        address    = a;
        write_data = d;
        s   = int'(a[9:6]);
        t   = a[31:10];
        idx = -1;
        for (int i = 0; i < mtag[s].size(); i++)
            if (mtag[s][i] == t) idx = i;
        e.h = 1'b0;
        if (w) begin
            e.h = (idx >= 0);
            if (idx >= 0) begin
                mdat[s][idx] = d;
            end else begin
                if (mtag[s].size() == 4) begin
                    void'(mtag[s].pop_front());
                    void'(mdat[s].pop_front());
                end
                mtag[s].push_back(t);
                mdat[s].push_back(d);
            end
            last_rd = d;
        end else if (r) begin
            e.h     = (idx >= 0);
            last_rd = (idx >= 0) ? mdat[s][idx] : 32'h0;
        end
        e.d = last_rd;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, hit, read_data, e.h, e.d);
            end
        end
    end

    initial begin : stim
        logic [31:0] a;
        logic [31:0] d;
        int          op;
        reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; write_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_state", hit, read_data, 1'b0, 32'h0);

        do_op("rd_empty", 1, 0, 32'h0040, 0);
        do_op("fill0", 0, 1, 32'h0040, 32'hAAAAAAAA);
        do_op("fill1", 0, 1, 32'h0840, 32'hBBBBBBBB);
        do_op("fill2", 0, 1, 32'h1040, 32'hCCCCCCCC);
        do_op("fill3", 0, 1, 32'h1840, 32'hDDDDDDDD);
        do_op("rd_fill0", 1, 0, 32'h0040, 0);
        do_op("rd_fill1", 1, 0, 32'h0840, 0);
        do_op("rd_fill2", 1, 0, 32'h1040, 0);
        do_op("rd_fill3", 1, 0, 32'h1840, 0);
        do_op("evict_wr", 0, 1, 32'h2040, 32'hEEEEEEEE);
        do_op("rd_evicted", 1, 0, 32'h0040, 0);
        do_op("rd_kept1", 1, 0, 32'h0840, 0);
        do_op("rd_kept2", 1, 0, 32'h1040, 0);
        do_op("rd_kept3", 1, 0, 32'h1840, 0);
        do_op("rd_new", 1, 0, 32'h2040, 0);
        do_op("wr_hit", 0, 1, 32'h0840, 32'h12345678);
        do_op("rd_wr_hit", 1, 0, 32'h0840, 0);
        do_op("evict2_wr", 0, 1, 32'h2840, 32'h0BADF00D);
        do_op("rd_evict2", 1, 0, 32'h0840, 0);
        do_op("wr_set2", 0, 1, 32'h0080, 32'h55AA55AA);
        do_op("rd_offset", 1, 0, 32'h00BC, 0);
        do_op("rd_set1_iso", 1, 0, 32'h1040, 0);
        do_op("rw_priority", 1, 1, 32'h0100, 32'h0F0F0F0F);
        do_op("rd_priority", 1, 0, 32'h0100, 0);
        do_op("idle", 0, 0, 32'h0100, 0);
        do_op("idle2", 0, 0, 32'h0000, 32'hFFFFFFFF);

        // Random traffic over a small tag pool in four sets forces eviction and hits.
        for (int n = 0; n < 400; n++) begin
            a  = {19'(0), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), 6'($urandom)};
            d  = $urandom;
            op = $urandom_range(0, 9);
            if (op < 4)      do_op("rand_wr", 0, 1, a, d);
            else if (op < 8) do_op("rand_rd", 1, 0, a, d);
            else if (op < 9) do_op("rand_rw", 1, 1, a, d);
            else             do_op("rand_idle", 0, 0, a, d);
        end
        do_op("pre_reset_wr", 0, 1, 32'h1040, 32'h13572468);

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        read  = 1'b0;
        write = 1'b0;
        reset = 1'b0;
        #1;
        check("async_reset", hit, read_data, 1'b0, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        do_op("post_rst_rd1", 1, 0, 32'h1040, 0);
        do_op("post_rst_rd2", 1, 0, 32'h2040, 0);
        do_op("post_rst_rd3", 1, 0, 32'h0080, 0);
        do_op("post_rst_wr", 0, 1, 32'h0040, 32'h600DCAFE);
        do_op("post_rst_rdb", 1, 0, 32'h0040, 0);

        repeat (4) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d responses pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
